adc_tap_opt_sm: RTL

//  Tap-delay optimizer for one ADC data lane, driven by the CC_OPT_DELAY command handler (start_opt/opt_done).

---
 rtl/adc_tap_opt_sm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/adc_tap_opt_sm.sv
// adc_tap_opt_sm: sweeps every IDELAY tap against the ADC test pattern and commits the centre of the widest passing eye.
// Optional feature macro OPT_EYE_MAP_EN exposes the per-tap pass map on eye_map.
module adc_tap_opt_sm #(
  parameter int                  ADC_BITS      = 14,
  parameter logic [ADC_BITS-1:0] TEST_PATTERN  = 14'h2A5A,
  parameter int                  NUM_TAPS      = 32,
  parameter int                  SETTLE_CYCLES = 16,
  parameter int                  SAMPLE_COUNT  = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_opt,
  output logic                opt_done,
  output logic                opt_error,
  input  logic [ADC_BITS-1:0] adc_data,
  input  logic                adc_valid,
  output logic [4:0]          tap_value,
  output logic                tap_load,
  output logic [4:0]          delay_value,
  output logic [5:0]          eye_width
`ifdef OPT_EYE_MAP_EN
  ,
  output logic [NUM_TAPS-1:0] eye_map
`endif
);

  localparam int TAP_W = 5;
  localparam int RUN_W = 6;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = $clog2(SAMPLE_COUNT + 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(SAMPLE_COUNT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, SETTLE, SAMPLE, RECORD, SCAN, COMMIT, FAIL, DONE, RESTORE
  } state_t;

  state_t              state;
  logic [TAP_W-1:0]    index;
  logic [SET_W-1:0]    settle_cnt;
  logic [SMP_W-1:0]    sample_cnt;
  logic                mismatch;
  logic [NUM_TAPS-1:0] pass_map;
  logic                load_pend;
  logic [TAP_W-1:0]    cur_start;
  logic [RUN_W-1:0]    cur_len;
  logic [TAP_W-1:0]    best_start;
  logic [RUN_W-1:0]    best_len;

  logic             scan_bit;
  logic [RUN_W-1:0] run_len_nxt;
  logic [TAP_W-1:0] run_start_nxt;
  logic [TAP_W-1:0] half_len;
  logic [TAP_W-1:0] centre;
  logic             load_busy;
  logic             abort;

  // During SCAN the tap index doubles as the pass-map walk pointer.
  assign scan_bit      = pass_map[index];
  assign run_len_nxt   = cur_len + RUN_W'(1);
  assign run_start_nxt = (cur_len == '0) ? index : cur_start;
  assign half_len      = TAP_W'((best_len - RUN_W'(1)) >> 1);
  assign centre        = best_start + half_len;
  assign load_busy     = load_pend | tap_load;
  assign abort         = !start_opt && (state != IDLE) && (state != DONE) && (state != RESTORE);

`ifdef OPT_EYE_MAP_EN
  assign eye_map = pass_map;
`endif

  // tap_value is written one cycle ahead of its strobe, and a new write waits for
  // any strobe in flight, so the IDELAY always sees a settled value around tap_load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      index       <= '0;
      settle_cnt  <= '0;
      sample_cnt  <= '0;
      mismatch    <= 1'b0;
      pass_map    <= '0;
      load_pend   <= 1'b0;
      cur_start   <= '0;
      cur_len     <= '0;
      best_start  <= '0;
      best_len    <= '0;
      opt_done    <= 1'b0;
      opt_error   <= 1'b0;
      tap_value   <= '0;
      tap_load    <= 1'b0;
      delay_value <= '0;
      eye_width   <= '0;
    end else begin
      tap_load  <= load_pend;
      load_pend <= 1'b0;
      if (abort) begin
        state <= RESTORE;
      end else begin
        case (state)
          IDLE: begin
            if (start_opt && !opt_done && !load_busy) begin
              index     <= '0;
              tap_value <= '0;
              load_pend <= 1'b1;
              opt_error <= 1'b0;
              pass_map  <= '0;
              state     <= LOAD;
            end
          end
          LOAD: begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              sample_cnt <= '0;
              mismatch   <= 1'b0;
              state      <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          SAMPLE: begin
            if (adc_valid) begin
              if (adc_data != TEST_PATTERN) mismatch <= 1'b1;
              if (sample_cnt == SAMPLE_LAST) state <= RECORD;
              sample_cnt <= sample_cnt + SMP_W'(1);
            end
          end
          RECORD: begin
            pass_map[index] <= !mismatch;
            if (index == LAST_TAP) begin
              index      <= '0;
              cur_start  <= '0;
              cur_len    <= '0;
              best_start <= '0;
              best_len   <= '0;
              state      <= SCAN;
            end else begin
              index     <= index + TAP_W'(1);
              tap_value <= index + TAP_W'(1);
              load_pend <= 1'b1;
              state     <= LOAD;
            end
          end
          SCAN: begin
            // Strict > keeps the lowest run on ties; runs never wrap past the last tap.
            if (scan_bit) begin
              cur_len   <= run_len_nxt;
              cur_start <= run_start_nxt;
              if (run_len_nxt > best_len) begin
                best_len   <= run_len_nxt;
                best_start <= run_start_nxt;
              end
            end else begin
              cur_len <= '0;
            end
            if (index == LAST_TAP) begin
              state <= (best_len == '0 && !scan_bit) ? FAIL : COMMIT;
            end else begin
              index <= index + TAP_W'(1);
            end
          end
          COMMIT: begin
            delay_value <= centre;
            tap_value   <= centre;
            eye_width   <= best_len;
            load_pend   <= 1'b1;
            opt_done    <= 1'b1;
            state       <= DONE;
          end
          FAIL: begin
            opt_error <= 1'b1;
            tap_value <= delay_value;
            eye_width <= '0;
            load_pend <= 1'b1;
            opt_done  <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            if (!start_opt) begin
              opt_done <= 1'b0;
              state    <= IDLE;
            end
          end
          RESTORE: begin
            if (!load_busy) begin
              tap_value <= delay_value;
              load_pend <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
